seq_detector_param: RTL
=======================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter PATTERN, default 4'b0110, PAT_W-bit power-up and reset pattern.
REQ-003 SHALL have parameter CNT_W, default 8, match-counter width, legal range 1..16.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port en, input, 1, bit-valid qualifier; x is consumed only when en=1.
REQ-007 SHALL have port x, input, 1, serial data bit.
REQ-008 SHALL have port overlap, input, 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL have port load, input, 1, pattern-load strobe.
REQ-010 SHALL have port pat_in, input, PAT_W, new pattern, captured when load=1.
REQ-011 SHALL have port z, output, 1, Mealy match flag.
REQ-012 SHALL have port match_cnt, output, CNT_W, saturating count of detected matches.

Function
REQ-013 SHALL hold pat_reg (PAT_W), win (last PAT_W-1 consumed bits), fill (0..PAT_W-1 valid bits in win) and cnt (CNT_W).
REQ-014 SHALL order bits so the first received bit of a sequence compares against pat_reg[PAT_W-1] and the newest bit against pat_reg[0].
REQ-015 SHALL drive z combinationally: z=1 iff en=1, load=0, reset=0, fill=PAT_W-1 and {win,x}==pat_reg.
REQ-016 SHALL consume the bit on a clock edge with en=1, load=0, reset=0: win shifts left taking x, fill increments and saturates at PAT_W-1.
REQ-017 SHALL, on a consuming edge where z=1 and overlap=0, clear fill to 0 so no bit of the matched sequence is reused.
REQ-018 SHALL, on a consuming edge where z=1 and overlap=1, shift normally so the matched bits remain usable by later matches.
REQ-019 SHALL, while en=0, hold win, fill and cnt unchanged and keep z=0.
REQ-020 SHALL, on an edge with load=1 and reset=0, set pat_reg<=pat_in and fill<=0, ignore en and x, and leave cnt unchanged.
REQ-021 SHALL keep z=0 during any cycle with load=1.
REQ-022 SHALL apply a change of overlap from the next match onward; the current window contents are kept.
REQ-023 SHALL increment cnt on every consuming edge with z=1, saturating at 2^CNT_W-1 with no wrap.
REQ-024 SHALL have a match latency of zero cycles: z is valid in the same cycle as the final pattern bit; match_cnt reflects the match one cycle later.

Reset
REQ-025 SHALL, on an edge with reset=1, set pat_reg<=PATTERN, win<=0, fill<=0 and cnt<=0; reset overrides load and en.
REQ-026 SHALL hold z=0 and match_cnt=0 after reset, and SHALL discard any partial sequence when reset is asserted mid-stream.

Configuration
REQ-027 SHALL compile the match counter in when macro SEQ_DETECTOR_PARAM_CNT_EN is defined, with cnt behaving per REQ-023.
REQ-028 SHALL, when SEQ_DETECTOR_PARAM_CNT_EN is undefined, contain no counter register and drive match_cnt constant 0; z behaviour is unchanged.

Verification
REQ-029 SHALL cover: defaults, overlap=1, en=1, stream 0,1,1,0,1,1,0 -> z=1 on bits 4 and 7 only; match_cnt=2.
REQ-030 SHALL cover: same stream with overlap=0 -> z=1 on bit 4 only; match_cnt=1.
REQ-031 SHALL cover: bits 0,1,1, then reset for 1 cycle, then 0 -> z=0 throughout; match_cnt=0.
REQ-032 SHALL cover: load with pat_in=1011, then overlap=1 stream 1,0,1,1,0,1,1 -> z=1 on bits 4 and 7; z=0 in the load cycle.
REQ-033 SHALL cover: stream 0,1,with en=0 for 3 cycles,1,0 -> z=1 on the final bit; idle cycles have no effect.
REQ-034 SHALL cover: CNT_W=2 with 5 matches -> match_cnt reads 3 after the third match and stays 3; with macro undefined -> match_cnt=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with a Mealy match flag.
// Features: overlapping or non-overlapping detection, a pattern that can be
// loaded at run time, and a bit-valid qualifier (en).
// Optional match counter: define SEQ_DETECTOR_PARAM_CNT_EN to build it in.
// Without that macro there is no counter register and match_cnt is tied to 0.
module seq_detector_param #(
  parameter int unsigned           PAT_W   = 4,
  parameter logic [PAT_W-1:0]      PATTERN = 4'b0110,
  parameter int unsigned           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             x,
  input  logic             overlap,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned         WinW    = PAT_W - 1;
  localparam int unsigned         FillW   = $clog2(PAT_W);
  localparam logic [FillW-1:0]    FillMax = FillW'(PAT_W - 1);

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic             consume;
  logic             full;

  // A bit is consumed only when qualified and not pre-empted by reset or load.
  assign consume = en & ~load & ~reset;
  assign full    = (fill_q == FillMax);
  // Oldest window bit lines up with pat_q[PAT_W-1], the live bit with pat_q[0].
  assign z       = consume & full & ({win_q, x} == pat_q);

  // Next-state for pattern, window and fill level.
  always_comb begin
    pat_d  = pat_q;
    win_d  = win_q;
    fill_d = fill_q;
    if (load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (en) begin
      win_d = WinW'({win_q, x});
      if (z && !overlap) begin
        // Non-overlapping: the matched bits must not contribute to a later match.
        fill_d = '0;
      end else if (!full) begin
        fill_d = fill_q + FillW'(1);
      end
    end
  end

  // State registers with synchronous reset; reset overrides load and en.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= PATTERN;
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      pat_q  <= pat_d;
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

`ifdef SEQ_DETECTOR_PARAM_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter; z already excludes load and reset cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (z && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule
